// File: rtl/vote_pkg.sv
// -----------------------------------------------------------------------------
// vote_pkg
// Shared types and helpers for the voting blocks.
//   vote_state_t  : session FSM states (IDLE, VOTING, RESULT)
//   f_popcount_w  : width needed to hold a popcount of n bits, $clog2(n+1)
// -----------------------------------------------------------------------------
package vote_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VOTING = 2'd1,
        RESULT = 2'd2
    } vote_state_t;

    function automatic int f_popcount_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vote_popcount.sv
// -----------------------------------------------------------------------------
// vote_popcount
// Combinational population count of an N_VOTERS-bit vector, built as a
// balanced binary adder tree over a power-of-two number of leaves.
// Ports:
//   bits   in   N_VOTERS                 vector to count
//   count  out  f_popcount_w(N_VOTERS)   number of set bits, zero-extended
// -----------------------------------------------------------------------------
module vote_popcount
    import vote_pkg::*;
#(
    parameter int N_VOTERS = 3
) (
    input  logic [N_VOTERS-1:0]               bits,
    output logic [f_popcount_w(N_VOTERS)-1:0] count
);

    localparam int          CNT_W  = f_popcount_w(N_VOTERS);
    localparam int unsigned LEAVES = 1 << $clog2(N_VOTERS);

    // Heap-ordered tree: node 0 is the root, leaves live at LEAVES-1 upward,
    // children of node j are 2j+1 and 2j+2. Unused leaves stay zero.
    always_comb begin : tree
        logic [CNT_W-1:0] node [2*LEAVES-1];
        for (int unsigned i = 0; i < 2*LEAVES-1; i++) begin
            node[i] = '0;
        end
        for (int unsigned i = 0; i < N_VOTERS; i++) begin
            node[LEAVES-1+i] = CNT_W'(bits[i]);
        end
        for (int unsigned i = LEAVES-1; i > 0; i--) begin
            node[i-1] = node[2*i-1] + node[2*i];
        end
        count = node[0];
    end

endmodule

// File: rtl/vote_judge_seq.sv
// -----------------------------------------------------------------------------
// vote_judge_seq
// Clocked voting-session judge: sticky ballots collected over a fixed window,
// result latched and held, abortable at any time while busy.
// Optional build macro: VOTE_EARLY_DECIDE_EN -- ends the window as soon as the
// pass threshold is reached or every voter has voted.
// Ports:
//   clk    in   1         system clock (rising edge)
//   rst_n  in   1         asynchronous active-low reset
//   start  in   1         session request, honoured only in IDLE
//   abort  in   1         cancel current session, clears results
//   VOTES  in   N_VOTERS  live per-voter yes lines
//   busy   out  1         session in VOTING or RESULT
//   done   out  1         single-cycle pulse on first RESULT cycle
//   X      out  1         motion passed (COUNT >= THRESH)
//   Y      out  1         no votes cast
//   COUNT  out  CNT_W     popcount of the final ballot
//   voted  out  N_VOTERS  sticky ballot register
// -----------------------------------------------------------------------------
module vote_judge_seq
    import vote_pkg::*;
#(
    parameter int N_VOTERS   = 3,
    parameter int THRESH     = 2,
    parameter int WINDOW_CYC = 16,
    parameter int HOLD_CYC   = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              abort,
    input  logic [N_VOTERS-1:0]               VOTES,
    output logic                              busy,
    output logic                              done,
    output logic                              X,
    output logic                              Y,
    output logic [f_popcount_w(N_VOTERS)-1:0] COUNT,
    output logic [N_VOTERS-1:0]               voted
);

    localparam int CNT_W  = f_popcount_w(N_VOTERS);
    localparam int WIN_W  = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [WIN_W-1:0]  WIN_LOAD  = WIN_W'(WINDOW_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]  THRESH_C  = CNT_W'(THRESH);

    // Elaboration-time parameter sanity checks
    if (N_VOTERS < 1 || N_VOTERS > 32) begin : g_bad_n
        $error("vote_judge_seq: N_VOTERS must be in 1..32");
    end
    if (THRESH < 1 || THRESH > N_VOTERS) begin : g_bad_thresh
        $error("vote_judge_seq: THRESH must be in 1..N_VOTERS");
    end
    if (WINDOW_CYC < 1) begin : g_bad_window
        $error("vote_judge_seq: WINDOW_CYC must be >= 1");
    end
    if (HOLD_CYC < 1) begin : g_bad_hold
        $error("vote_judge_seq: HOLD_CYC must be >= 1");
    end

    vote_state_t         state;
    vote_state_t         state_nxt;
    logic [WIN_W-1:0]    win_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [N_VOTERS-1:0] ballot_now;
    logic [CNT_W-1:0]    pop_now;
    logic                decide;
    logic                accept;
    logic                kill;
    logic                latch;

    // The ballot including this cycle's votes, so the last window cycle counts.
    assign ballot_now = voted | VOTES;

    vote_popcount #(
        .N_VOTERS (N_VOTERS)
    ) u_popcount (
        .bits  (ballot_now),
        .count (pop_now)
    );

`ifdef VOTE_EARLY_DECIDE_EN
    assign decide = (win_cnt == '0) || (pop_now >= THRESH_C) || (&ballot_now);
`else
    assign decide = (win_cnt == '0);
`endif

    assign busy = (state != IDLE);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and datapath strobes (abort wins over everything)
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        kill      = 1'b0;
        latch     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    accept    = 1'b1;
                    state_nxt = VOTING;
                end
            end
            VOTING: begin
                if (abort) begin
                    kill      = 1'b1;
                    state_nxt = IDLE;
                end else if (decide) begin
                    latch     = 1'b1;
                    state_nxt = RESULT;
                end
            end
            RESULT: begin
                if (abort) begin
                    kill      = 1'b1;
                    state_nxt = IDLE;
                end else if (hold_cnt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Window / hold counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            if (accept) begin
                win_cnt <= WIN_LOAD;
            end else if (kill || latch) begin
                win_cnt <= '0;
            end else if (state == VOTING) begin
                win_cnt <= win_cnt - 1'b1;
            end

            if (latch) begin
                hold_cnt <= HOLD_LOAD;
            end else if (kill) begin
                hold_cnt <= '0;
            end else if (state == RESULT && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Ballot and result registers; results persist until start/abort/reset
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            voted <= '0;
            X     <= 1'b0;
            Y     <= 1'b0;
            COUNT <= '0;
            done  <= 1'b0;
        end else begin
            done <= latch;
            if (accept || kill) begin
                voted <= '0;
                X     <= 1'b0;
                Y     <= 1'b0;
                COUNT <= '0;
            end else begin
                if (state == VOTING) begin
                    voted <= ballot_now;
                end
                if (latch) begin
                    X     <= (pop_now >= THRESH_C);
                    Y     <= (pop_now == '0);
                    COUNT <= pop_now;
                end
            end
        end
    end

endmodule

// File: tb/tb_vote_judge_seq.sv
module tb_vote_judge_seq;

    localparam int N    = 3;
    localparam int THR  = 2;
    localparam int WIN  = 16;
    localparam int HOLD = 8;
    localparam int CW   = $clog2(N + 1);
    localparam int LEN  = WIN + HOLD + 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [N-1:0]  VOTES = '0;
    logic          busy;
    logic          done;
    logic          X;
    logic          Y;
    logic [CW-1:0] COUNT;
    logic [N-1:0]  voted;

    int n_checks = 0;
    int n_fail   = 0;

    // vseq[c] is the VOTES value driven in cycle T+c (T = start cycle)
    logic [N-1:0]  vseq [LEN];
    logic          ret_x;
    logic          ret_y;
    int            ret_cnt;
    logic [N-1:0]  ret_voted;

    always #5 clk = ~clk;

    vote_judge_seq #(
        .N_VOTERS   (N),
        .THRESH     (THR),
        .WINDOW_CYC (WIN),
        .HOLD_CYC   (HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .VOTES (VOTES),
        .busy  (busy),
        .done  (done),
        .X     (X),
        .Y     (Y),
        .COUNT (COUNT),
        .voted (voted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_zero();
        for (int k = 0; k < LEN; k++) vseq[k] = '0;
    endtask

    task automatic fill_random();
        for (int k = 0; k < LEN; k++)
            vseq[k] = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
    endtask

    // One session from the start cycle T. Expectations come from the rules:
    // final ballot = OR of votes in window cycles 1..e, result visible from
    // cycle e+1, busy through e+HOLD, abort at cycle a wipes everything from a+1.
    task automatic run_session(input int abort_in, input bit rnd_start, input string name);
        int           e;
        int           a;
        int           lim;
        int           last;
        int           o;
        int           exp_c;
        bit           ab;
        logic [N-1:0] fin;
        logic [N-1:0] seen;
        logic         exp_x;
        logic         exp_y;

        e   = WIN;
        fin = '0;
        for (int k = 1; k <= WIN; k++) begin
            fin |= vseq[k];
`ifdef VOTE_EARLY_DECIDE_EN
            if ($countones(fin) >= THR || &fin) begin
                e = k;
                break;
            end
`endif
        end

        a = (abort_in > e + HOLD) ? 0 : abort_in;
        lim  = (a > 0) ? a : e + HOLD;
        last = (a > 0) ? a + 1 : e + HOLD + 1;
        seen  = '0;
        exp_x = 1'b0;
        exp_y = 1'b0;
        exp_c = 0;

        for (int c = 0; c <= last; c++) begin
            start = (c == 0) || (rnd_start && c <= lim && $urandom_range(0, 2) == 0);
            abort = (a > 0 && c == a);
            VOTES = vseq[c];
            tick();
            o  = c + 1;
            ab = (a > 0 && o > a);
            if (o - 1 >= 1 && o - 1 <= e) seen |= vseq[o-1];
            exp_c = (ab || o <= e) ? 0 : $countones(fin);
            exp_x = !ab && o > e && ($countones(fin) >= THR);
            exp_y = !ab && o > e && (fin == '0);
            check($sformatf("%s busy c%0d", name, o), busy, !ab && o <= e + HOLD);
            check($sformatf("%s done c%0d", name, o), done, !ab && o == e + 1);
            check($sformatf("%s voted c%0d", name, o), voted, ab ? '0 : seen);
            check($sformatf("%s count c%0d", name, o), COUNT, exp_c);
            check($sformatf("%s x c%0d", name, o), X, exp_x);
            check($sformatf("%s y c%0d", name, o), Y, exp_y);
        end
        start     = 1'b0;
        abort     = 1'b0;
        VOTES     = '0;
        ret_x     = exp_x;
        ret_y     = exp_y;
        ret_cnt   = exp_c;
        ret_voted = ab ? '0 : seen;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst x", X, 0);
        check("rst y", Y, 0);
        check("rst count", COUNT, 0);
        check("rst voted", voted, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst busy", busy, 0);

        // no votes at all
        fill_zero();
        run_session(0, 0, "t1_none");

        // two voters at separate times
        fill_zero();
        vseq[2] = 3'b001;
        vseq[9] = 3'b100;
        run_session(0, 0, "t2_two");

        // vote on last window cycle counts, one after the window and one on T do not
        fill_zero();
        vseq[0]   = 3'b111;
        vseq[WIN] = 3'b010;
        vseq[WIN+1] = 3'b111;
        run_session(0, 1, "t3_last");

        // start with abort in IDLE: no session, results retained
        start = 1'b1;
        abort = 1'b1;
        VOTES = '1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        VOTES = '0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("sa_idle busy %0d", i), busy, 0);
            check($sformatf("sa_idle done %0d", i), done, 0);
            check($sformatf("sa_idle x %0d", i), X, ret_x);
            check($sformatf("sa_idle y %0d", i), Y, ret_y);
            check($sformatf("sa_idle count %0d", i), COUNT, ret_cnt);
            check($sformatf("sa_idle voted %0d", i), voted, ret_voted);
            tick();
        end

        // abort mid-window with voted=011
        fill_zero();
        vseq[1] = 3'b001;
        vseq[3] = 3'b010;
        run_session(5, 0, "t4_abort");

        // randomized sessions, some aborted, with stray start pulses
        for (int s = 0; s < 30; s++) begin
            fill_random();
            run_session(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, WIN + HOLD)) : 0,
                        1'b1, $sformatf("rnd%0d", s));
        end

        // asynchronous reset in the middle of VOTING
        start = 1'b1;
        tick();
        start = 1'b0;
        VOTES = 3'b101;
        tick();
        tick();
        check("arst pre busy", busy, 1);
        check("arst pre voted", voted, 3'b101);
        #2 rst_n = 1'b0;
        #1;
        check("arst busy", busy, 0);
        check("arst done", done, 0);
        check("arst x", X, 0);
        check("arst y", Y, 0);
        check("arst count", COUNT, 0);
        check("arst voted", voted, 0);
        tick();
        rst_n = 1'b1;
        VOTES = '0;
        tick();
        check("arst idle busy", busy, 0);
        fill_zero();
        vseq[4] = 3'b110;
        run_session(0, 0, "t6_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vote_judge_seq.md
Name: vote_judge_seq

Overview:
- Parametrised, clocked successor to the combinational 3-input vote judge.
- Runs timed voting sessions over N_VOTERS voter lines with sticky ballots, a programmable pass threshold, a result-hold phase, and abort.
- Drives X (motion passed) and Y (no votes cast), keeping the legacy X/Y meaning.
- Sits between debounced voter inputs and the display/indicator logic.

Parameters:
- N_VOTERS, 3, number of voter inputs; range 1..32.
- THRESH, 2, minimum number of "yes" votes for X=1; must satisfy 1 <= THRESH <= N_VOTERS. Elaboration $error otherwise.
- WINDOW_CYC, 16, length of the voting window in cycles; must be >= 1.
- HOLD_CYC, 8, number of cycles spent in the RESULT state; must be >= 1.
- CNT_W (localparam), $clog2(N_VOTERS+1), width of COUNT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  session request; accepted only in IDLE.
- abort  in  1  cancel the current session.
- VOTES  in  N_VOTERS  per-voter yes line; 1 = yes.
- busy  out  1  high in VOTING and RESULT.
- done  out  1  one-cycle pulse on the first RESULT cycle.
- X  out  1  pass: COUNT >= THRESH.
- Y  out  1  no votes: ballot all zero.
- COUNT  out  CNT_W  popcount of the final ballot.
- voted  out  N_VOTERS  live sticky ballot register.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - busy, done, X, Y, COUNT, voted and the window/hold counters are all 0.
- FSM states: IDLE, VOTING, RESULT.
- IDLE:
  - Let cycle T be the cycle where start=1 and abort=0.
  - At T: ballot cleared, X/Y/COUNT cleared, window counter loaded with WINDOW_CYC-1.
  - Next state is VOTING, so busy=1 from T+1.
- VOTING:
  - Each cycle: ballot <= ballot | VOTES. Votes are sticky and cannot be withdrawn.
  - Each cycle the counter decrements.
  - VOTES is sampled in exactly WINDOW_CYC cycles, T+1 .. T+WINDOW_CYC, including the last one.
  - In the cycle where the counter is 0, the result is computed from (ballot | VOTES):
    - X <= (popcount >= THRESH)
    - Y <= (popcount == 0)
    - COUNT <= popcount
  - Next state is RESULT.
  - start is ignored in this state.
- RESULT:
  - Entered at T+WINDOW_CYC+1; done=1 in that cycle only.
  - Hold counter runs HOLD_CYC cycles, then IDLE.
  - busy=0 from T+WINDOW_CYC+1+HOLD_CYC.
  - start is ignored in this state.
- Result retention: X/Y/COUNT/voted keep their values through RESULT and in IDLE. They are cleared only by the next accepted start, abort, or reset.
- abort:
  - In VOTING or RESULT: next state IDLE. X, Y, COUNT and voted are cleared, and no done pulse is produced.
  - abort has priority over window expiry and over start in the same cycle.
  - abort in IDLE: same-cycle start is ignored; no other effect.
- Legacy equivalence: with N_VOTERS=3, THRESH=2, the final ballot→(X,Y) map matches the old truth table: 000→(0,1); exactly one bit set→(0,0); two or three bits set→(1,0).
- Popcount: combinational, zero-extended to CNT_W; no overflow by construction.
- X and Y are never both 1, since THRESH >= 1.

Optional Feature:
- Macro: VOTE_EARLY_DECIDE_EN.
- Defined: in VOTING, the session ends early in the first cycle where either popcount(ballot|VOTES) >= THRESH or (ballot|VOTES) is all ones.
  - The result is latched in that cycle; RESULT and done follow in the next cycle.
  - The window counter is discarded.
- Undefined: the full WINDOW_CYC window always runs; no early exit logic is synthesised.

Decomposition:
- Shared package vote_pkg:
  - state enum typedef vote_state_t {IDLE, VOTING, RESULT}
  - constant function f_popcount_w(n) returning $clog2(n+1)
- One natural sub-module: vote_popcount.
  - Parametrised by N_VOTERS, combinational adder tree.
  - Input bits [N-1:0], output count [CNT_W-1:0].
  - Reused by later display/score blocks.

Test Plan:
- N=3, THRESH=2, WINDOW=16, HOLD=8. start at T; VOTES=3'b000 throughout → done at T+17; X=0, Y=1, COUNT=0; busy=0 at T+25.
- Same config; VOTES=3'b001 at T+2, 3'b100 at T+9, otherwise 0 → voted=3'b101; X=1, Y=0, COUNT=2; done exactly one cycle.
- Same config; VOTES=3'b010 only on the last window cycle T+16 → vote counted: COUNT=1, X=0, Y=0. A vote at T+17 is ignored.
- abort at T+5 with voted=3'b011 → IDLE at T+6; X=Y=COUNT=voted=0; done never pulses. start and abort together in IDLE → no session.
- N=5, THRESH=4 with VOTE_EARLY_DECIDE_EN; VOTES=5'b11110 at T+3 → done at T+4, X=1, COUNT=4. Without the macro → done at T+17.
- start pulses during VOTING/RESULT are ignored. Async rst_n low mid-VOTING → all outputs 0 immediately, state IDLE.
